// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding controller.
//   fwd_sel_t     : 3:1 operand mux select
//   FWD_REGFILE   : operand comes from the ID/EX register-file value
//   FWD_WB        : operand comes from MEM/WB writeback data
//   FWD_MEM       : operand comes from the EX/MEM ALU result
//   pick_sel()    : priority-resolves the two producer hits into a select
package fwd_hazard_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_WB      = 2'b01;
  localparam fwd_sel_t FWD_MEM     = 2'b10;

  // The younger producer (currently in EX, next in MEM) holds the newest value, so it wins.
  function automatic fwd_sel_t pick_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_MEM;
    end else if (mem_hit) begin
      return FWD_WB;
    end
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle of the forwarding/hazard controller.
//   master : pipeline control (drives ID instruction info, flush, hold)
//   slave  : the controller (drives stall, bubble, forward selects, stall counter)
// Signals:
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_mem_read
//   flush, hold, stall, bubble, forward_a, forward_b, stall_count
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned CNT_WIDTH      = 32
);

  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      flush;
  logic                      hold;
  logic                      stall;
  logic                      bubble;
  logic [SEL_WIDTH-1:0]      forward_a;
  logic [SEL_WIDTH-1:0]      forward_b;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
           id_mem_read, flush, hold,
    input  stall, bubble, forward_a, forward_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
           id_mem_read, flush, hold,
    output stall, bubble, forward_a, forward_b, stall_count
  );

endinterface

// File: rtl/fwd_sel_compare.sv
// Compares one ID source register against the EX and MEM destination tags.
//   rs, rs_used                         : source register and whether it is read
//   ex_valid/ex_reg_write/ex_mem_read/ex_rd : tag of the instruction now in EX
//   mem_valid/mem_reg_write/mem_rd      : tag of the instruction now in MEM
//   sel                                 : forward select for this operand
//   load_hazard                         : EX holds a load whose result this operand needs
module fwd_sel_compare
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      rs_used,
  input  logic                      ex_valid,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output fwd_sel_t                  sel,
  output logic                      load_hazard
);

  logic ex_rd_hit;
  logic ex_hit;
  logic mem_hit;

  // x0 is hardwired to zero, so it never creates a dependency.
  assign ex_rd_hit   = rs_used && ex_valid && (ex_rd != '0) && (ex_rd == rs);
  assign ex_hit      = ex_rd_hit && ex_reg_write;
  assign mem_hit     = rs_used && mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
  assign load_hazard = ex_rd_hit && ex_mem_read;
  assign sel         = pick_sel(ex_hit, mem_hit);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-forwarding and load-use hazard controller.
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : slave side of fwd_hazard_ctrl_if (ID instruction info, flush, hold in;
//                stall, bubble, registered forward selects and stall counter out)
// Destination tags are tracked for EX and MEM only: a producer in WB is covered by the
// write-through register file, so a WB tag would have no reader.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_ctrl_if.slave  bus
);

  logic                      ex_valid_q;
  logic                      ex_reg_write_q;
  logic                      ex_mem_read_q;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q;
  logic                      mem_valid_q;
  logic                      mem_reg_write_q;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
  logic [SEL_WIDTH-1:0]      forward_a_q;
  logic [SEL_WIDTH-1:0]      forward_b_q;
  logic [CNT_WIDTH-1:0]      stall_count_q;
  logic [CNT_WIDTH-1:0]      stall_count_d;

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     haz_a;
  logic     haz_b;
  logic     load_use;
  logic     stall;
  logic     bubble;
  logic     issue;

  fwd_sel_compare #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_cmp_rs1 (
    .rs           (bus.id_rs1),
    .rs_used      (bus.id_rs1_used),
    .ex_valid     (ex_valid_q),
    .ex_reg_write (ex_reg_write_q),
    .ex_mem_read  (ex_mem_read_q),
    .ex_rd        (ex_rd_q),
    .mem_valid    (mem_valid_q),
    .mem_reg_write(mem_reg_write_q),
    .mem_rd       (mem_rd_q),
    .sel          (sel_a),
    .load_hazard  (haz_a)
  );

  fwd_sel_compare #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_cmp_rs2 (
    .rs           (bus.id_rs2),
    .rs_used      (bus.id_rs2_used),
    .ex_valid     (ex_valid_q),
    .ex_reg_write (ex_reg_write_q),
    .ex_mem_read  (ex_mem_read_q),
    .ex_rd        (ex_rd_q),
    .mem_valid    (mem_valid_q),
    .mem_reg_write(mem_reg_write_q),
    .mem_rd       (mem_rd_q),
    .sel          (sel_b),
    .load_hazard  (haz_b)
  );

  // hold > flush > load-use. A flushed consumer is killed, so it needs no stall.
  always_comb begin
    load_use = bus.id_valid && (haz_a || haz_b);
    stall    = !bus.hold && !bus.flush && load_use;
    bubble   = !bus.hold && (bus.flush || load_use);
    issue    = bus.id_valid && !bus.flush && !load_use;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_rd_q        <= '0;
      forward_a_q     <= SEL_WIDTH'(FWD_REGFILE);
      forward_b_q     <= SEL_WIDTH'(FWD_REGFILE);
      stall_count_q   <= '0;
    end else if (!bus.hold) begin
      // EX -> MEM shifts unconditionally; a stalled or killed ID slot becomes a bubble.
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_rd_q        <= ex_rd_q;
      ex_valid_q      <= issue;
      ex_reg_write_q  <= bus.id_reg_write;
      ex_mem_read_q   <= bus.id_mem_read;
      ex_rd_q         <= bus.id_rd;
      forward_a_q     <= issue ? SEL_WIDTH'(sel_a) : SEL_WIDTH'(FWD_REGFILE);
      forward_b_q     <= issue ? SEL_WIDTH'(sel_b) : SEL_WIDTH'(FWD_REGFILE);
      stall_count_q   <= stall_count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.bubble      = bubble;
  assign bus.forward_a   = forward_a_q;
  assign bus.forward_b   = forward_b_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed test-plan sequences plus random
// instruction streams, checked against a model of in-flight instructions by age.
// A second instance with a 3-bit counter exercises stall_count saturation.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic reset;

  fwd_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(32)) bus ();
  fwd_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(3)) bus_s ();

  fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2), .CNT_WIDTH(3)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_rs1       = bus.id_rs1;
  assign bus_s.id_rs2       = bus.id_rs2;
  assign bus_s.id_rs1_used  = bus.id_rs1_used;
  assign bus_s.id_rs2_used  = bus.id_rs2_used;
  assign bus_s.id_rd        = bus.id_rd;
  assign bus_s.id_reg_write = bus.id_reg_write;
  assign bus_s.id_mem_read  = bus.id_mem_read;
  assign bus_s.flush        = bus.flush;
  assign bus_s.hold         = bus.hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: flight[0] is the instruction now in EX, flight[1] the one in MEM.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t   flight[2];
  int     exp_fa;
  int     exp_fb;
  longint exp_cnt;
  int     exp_cnt_s;
  bit     last_stall;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) flight[i] = '{0, 0, 0, 0};
    exp_fa     = 0;
    exp_fb     = 0;
    exp_cnt    = 0;
    exp_cnt_s  = 0;
    last_stall = 0;
  endfunction

  // Newest in-flight writer of rs decides the source: age 0 -> EX/MEM result, age 1 -> WB.
  function automatic int src_sel(input int rs, input bit used);
    if (!used) return 0;
    for (int age = 0; age < 2; age++) begin
      if (flight[age].v && flight[age].rw && flight[age].rd != 0 && flight[age].rd == rs)
        return (age == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit load_to(input int rs, input bit used);
    return used && flight[0].v && flight[0].mr && flight[0].rd != 0 && flight[0].rd == rs;
  endfunction

  // One pipeline cycle: drive ID/control, check against the model, advance the model.
  task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit rw, input bit mr, input bit fl, input bit hd);
    bit lu, es, eb, enters;
    @(negedge clk);
    bus.id_valid     = v;
    bus.id_rs1       = 5'(rs1);
    bus.id_rs2       = 5'(rs2);
    bus.id_rs1_used  = u1;
    bus.id_rs2_used  = u2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
    bus.hold         = hd;
    #1;
    lu = v && (load_to(rs1, u1) || load_to(rs2, u2));
    es = !hd && !fl && lu;
    eb = !hd && (fl || lu);
    chk("stall", 32'(bus.stall), 32'(es));
    chk("bubble", 32'(bus.bubble), 32'(eb));
    chk("forward_a", 32'(bus.forward_a), 32'(exp_fa));
    chk("forward_b", 32'(bus.forward_b), 32'(exp_fb));
    chk("stall_count", bus.stall_count, exp_cnt[31:0]);
    chk("stall_count_sat", 32'(bus_s.stall_count), 32'(exp_cnt_s));
    last_stall = es;
    if (!hd) begin
      enters = v && !fl && !lu;
      exp_fa = enters ? src_sel(rs1, u1) : 0;
      exp_fb = enters ? src_sel(rs2, u2) : 0;
      flight[1] = flight[0];
      flight[0] = enters ? '{1, rd, rw, mr} : '{0, 0, 0, 0};
      if (es) begin
        if (exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
        if (exp_cnt_s != 7) exp_cnt_s++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthands: ALU op, load, nop.
  task automatic alu(input int rd, input int rs1, input int rs2, input bit fl = 0,
                     input bit hd = 0);
    step(1, rs1, rs2, 1, 1, rd, 1, 0, fl, hd);
  endtask

  task automatic load(input int rd, input int rs1);
    step(1, rs1, 0, 1, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic nop(input bit hd = 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
  endtask

  longint c0;
  int     r_rs1, r_rs2, r_rd;
  bit     r_v, r_u1, r_u2, r_rw, r_mr;

  initial begin
    bus.id_valid     = 0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_rs1_used  = 0;
    bus.id_rs2_used  = 0;
    bus.id_rd        = '0;
    bus.id_reg_write = 0;
    bus.id_mem_read  = 0;
    bus.flush        = 0;
    bus.hold         = 0;
    reset            = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_bubble", 32'(bus.bubble), 32'd0);
    chk("rst_fa", 32'(bus.forward_a), 32'd0);
    chk("rst_fb", 32'(bus.forward_b), 32'd0);
    chk("rst_cnt", bus.stall_count, 32'd0);

    // 1: back-to-back ALU dependency -> EX/MEM forward on operand A.
    alu(5, 1, 2);
    alu(6, 5, 7);
    chk("t1_fa", 32'(bus.forward_a), 32'd2);
    chk("t1_fb", 32'(bus.forward_b), 32'd0);
    chk("t1_cnt", bus.stall_count, 32'd0);

    // 2: distance-two dependency -> WB forward on operand B.
    alu(5, 1, 2);
    nop();
    alu(8, 1, 5);
    chk("t2_fa", 32'(bus.forward_a), 32'd0);
    chk("t2_fb", 32'(bus.forward_b), 32'd1);

    // 3: two producers of x5, newest wins; x0 never forwards.
    alu(5, 1, 2);
    alu(5, 3, 4);
    alu(9, 5, 5);
    chk("t3_fa", 32'(bus.forward_a), 32'd2);
    chk("t3_fb", 32'(bus.forward_b), 32'd2);
    alu(0, 1, 2);
    alu(0, 3, 4);
    alu(9, 0, 0);
    chk("t3_x0_fa", 32'(bus.forward_a), 32'd0);
    chk("t3_x0_fb", 32'(bus.forward_b), 32'd0);

    // 4: load-use costs one stall, then the consumer forwards from WB.
    nop();
    c0 = exp_cnt;
    load(5, 2);
    alu(6, 5, 1);
    chk("t4_stalled", 32'(last_stall), 32'd1);
    chk("t4_cnt", bus.stall_count, 32'(c0 + 1));
    chk("t4_bubble_fa", 32'(bus.forward_a), 32'd0);
    alu(6, 5, 1);
    chk("t4_fa", 32'(bus.forward_a), 32'd1);

    // 5: flush overrides load-use; hold freezes selects.
    c0 = exp_cnt;
    load(5, 2);
    alu(6, 5, 1, 1, 0);
    chk("t5_cnt", bus.stall_count, 32'(c0));
    alu(5, 1, 2);
    alu(6, 5, 5);
    for (int i = 0; i < 3; i++) begin
      alu(7, 1, 1, 0, 1);
      chk("t5_hold_fa", 32'(bus.forward_a), 32'd2);
      chk("t5_hold_fb", 32'(bus.forward_b), 32'd2);
    end
    alu(7, 6, 1);
    chk("t5_resume_fa", 32'(bus.forward_a), 32'd2);

    // Random streams; a stalled or held ID keeps its instruction.
    for (int n = 0; n < 600; n++) begin
      if (!last_stall && !bus.hold) begin
        r_v   = ($urandom % 100) < 85;
        r_rs1 = int'($urandom % 4);
        r_rs2 = int'($urandom % 4);
        r_u1  = ($urandom % 100) < 80;
        r_u2  = ($urandom % 100) < 60;
        r_rd  = int'($urandom % 4);
        r_rw  = ($urandom % 100) < 80;
        r_mr  = r_rw && (($urandom % 100) < 50);
      end
      step(r_v, r_rs1, r_rs2, r_u1, r_u2, r_rd, r_rw, r_mr,
           ($urandom % 100) < 8, ($urandom % 100) < 10);
    end

    // 6: asynchronous reset in the middle of a load-use stall.
    nop();
    load(5, 2);
    @(negedge clk);
    bus.id_valid     = 1;
    bus.id_rs1       = 5'd5;
    bus.id_rs2       = 5'd1;
    bus.id_rs1_used  = 1;
    bus.id_rs2_used  = 1;
    bus.id_rd        = 5'd6;
    bus.id_reg_write = 1;
    bus.id_mem_read  = 0;
    bus.flush        = 0;
    bus.hold         = 0;
    #1;
    chk("t6_pre_stall", 32'(bus.stall), 32'd1);
    reset = 1;
    #1;
    chk("t6_stall", 32'(bus.stall), 32'd0);
    chk("t6_bubble", 32'(bus.bubble), 32'd0);
    chk("t6_fa", 32'(bus.forward_a), 32'd0);
    chk("t6_fb", 32'(bus.forward_b), 32'd0);
    chk("t6_cnt", bus.stall_count, 32'd0);
    chk("t6_cnt_s", 32'(bus_s.stall_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    alu(6, 5, 1);
    alu(7, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Controller for the two 3:1 operand-forwarding muxes in the EX stage of the 5-stage RISC-V pipeline. It tracks the destination-register tags of in-flight instructions internally through EX, MEM and WB. It produces the registered forward selects for both ALU operands, detects load-use hazards and generates stall/bubble, handles branch flush and global hold, and counts stall cycles.

Parameters:
REG_ADDR_WIDTH, 5, register index width
SEL_WIDTH, 2, forward-select width (matches 3:1 mux select)
CNT_WIDTH, 32, stall counter width

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_ADDR_WIDTH  source 1 of ID instruction
id_rs2  input  REG_ADDR_WIDTH  source 2 of ID instruction
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_ADDR_WIDTH  destination of ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
flush  input  1  branch/jump taken in EX; kill IF and ID
hold  input  1  global freeze (memory wait)
stall  output  1  hold PC and IF/ID this cycle (combinational)
bubble  output  1  load NOP into ID/EX this cycle (combinational)
forward_a  output  SEL_WIDTH  EX operand-A mux select (registered)
forward_b  output  SEL_WIDTH  EX operand-B mux select (registered)
stall_count  output  CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- Select encoding: 00 = ID/EX register-file value; 01 = MEM/WB writeback data; 10 = EX/MEM ALU result; 11 is never driven.
- Internal tags per stage (EX, MEM, WB): valid, rd, reg_write, mem_read. Tags shift EX->MEM->WB each clock unless hold.
- Forward select is computed in ID against the EX tag (becomes MEM -> 10) and the MEM tag (becomes WB -> 01). It is registered into forward_a/b together with the ID->EX tag shift, so the selects are valid in the consumer's EX cycle (latency 1).
- A match requires: tag valid, reg_write=1, rd!=0, rd==rs, and rs_used=1. The EX-tag match (10) has priority over the MEM-tag match (01). Otherwise the select is 00.
- The register file is write-through. A producer in WB during the consumer's ID needs no forwarding.
- Load-use: if id_valid and the EX tag is a valid load with rd!=0 matching a used rs, then stall=1 and bubble=1 for exactly one cycle.
  - EX receives an invalid tag, and forward_a/b are loaded with 00.
  - Next cycle the load is in MEM, and the consumer resolves to 01 on its way to EX.
- Flush: the EX tag is loaded invalid, forward_a/b are loaded with 00, and stall=0, bubble=1.
- Priority: hold > flush > load-use.
  - hold=1: all tags, forward_a/b and stall_count keep their values; stall=0, bubble=0.
  - flush concurrent with load-use: stall=0, because the hazarding instruction is killed.
- id_valid=0: EX receives an invalid tag and selects are 00.
- stall_count increments on each cycle with stall=1 and hold=0, and saturates at all-ones.
- Reset (asynchronous, any time, including mid-stall): all tags invalid, forward_a/b=00, stall_count=0. stall and bubble therefore read 0 immediately.

Decomposition:
- Shared include ctrl_defs.vh holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - tag field widths/offsets
- Sub-module fwd_sel_compare (combinational): takes one rs, rs_used, and the EX/MEM tags; returns a 2-bit select and a load-hazard flag. It is instantiated twice (rs1, rs2).
- Tag pipeline, priority logic and counter live in the top.

Test Plan:
1. add x5 then sub x6,x5,x7 back-to-back -> forward_a=10, forward_b=00 in sub's EX cycle; stall never 1.
2. add x5, nop, or x8,x1,x5 -> forward_b=01 in or's EX cycle.
3. add x5 (i), add x5 (i+1), sub x9,x5,x5 (i+2) -> forward_a=forward_b=10, so the newest producer wins; same sequence with rd=x0 -> both 00.
4. lw x5 then add x6,x5,x1 -> stall=1, bubble=1 for one cycle, stall_count 0->1; add enters EX one cycle late with forward_a=01.
5. lw x5 then add using x5 with flush=1 in the hazard cycle -> stall=0, bubble=1, stall_count unchanged; hold=1 for 3 cycles mid-sequence -> forward_a/b and tags frozen, resuming identically.
6. Assert reset during an active load-use stall -> stall, bubble, forward_a/b and stall_count all 0 before the next clk edge; stall_count saturation checked by forcing near-max value.
